aes_inv_shift_rows_stream: RTL and testbench



---
 rtl/aes_pkg.sv | 16 +
 rtl/aes_inv_shift_rows_stream_if.sv | 13 +
 rtl/aes_shift_rows_perm.sv | 19 +
 rtl/aes_inv_shift_rows_stream.sv | 100 ++++++++++
 tb/tb_aes_inv_shift_rows_stream.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES byte/word/state types and column constants
package aes_pkg;

  localparam int NB              = 4;
  localparam int BEATS_PER_STATE = 4;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] state_t;

  // State is column-major: column 0 in the top word, row 0 in the top byte of each column.
  function automatic byte_t state_byte(input state_t s, input int r, input int c);
    return s[127-8*(4*c+r) -: 8];
  endfunction

endpackage

// File: rtl/aes_inv_shift_rows_stream_if.sv
// rtl/aes_inv_shift_rows_stream_if.sv - column-serial valid/ready stream with last marker
interface aes_inv_shift_rows_stream_if;
  import aes_pkg::*;

  logic  valid;
  logic  ready;
  word_t col;
  logic  last;

  modport master (output valid, output col, output last, input ready);
  modport slave  (input valid, input col, input last, output ready);

endinterface

// File: rtl/aes_shift_rows_perm.sv
// rtl/aes_shift_rows_perm.sv - combinational (Inv)ShiftRows byte permutation of a full state
module aes_shift_rows_perm
  import aes_pkg::*;
#(
  parameter bit INVERSE = 1'b1
) (
  input  state_t din,
  output state_t dout
);

  // Pure wiring: each output byte picks a fixed source column in the same row.
  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int SRC = INVERSE ? (c + NB - r) % NB : (c + r) % NB;
      assign dout[127-8*(4*c+r) -: 8] = state_byte(din, r, SRC);
    end
  end

endmodule

// File: rtl/aes_inv_shift_rows_stream.sv
// rtl/aes_inv_shift_rows_stream.sv - ping-pong buffered column-serial InvShiftRows stage
module aes_inv_shift_rows_stream
  import aes_pkg::*;
#(
  parameter bit INVERSE = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst,
  aes_inv_shift_rows_stream_if.slave          up,
  aes_inv_shift_rows_stream_if.master         dn,
  output logic                                busy
);

  localparam logic [1:0] LAST_BEAT = 2'(BEATS_PER_STATE - 1);

  word_t      bank [2][NB];
  logic [1:0] full, full_nxt;
  logic       wr_sel, rd_sel;
  logic [1:0] wr_beat, rd_beat;

  logic       in_ready, out_valid, in_fire, out_fire;
  state_t     rd_state, perm_state;
  word_t      sel_col;
  logic       unused_last;

  assign unused_last = up.last;

  // in_ready depends only on registered state; held high while in reset.
  assign in_ready  = rst | ~full[wr_sel];
  assign out_valid = ~rst & full[rd_sel];
  assign in_fire   = up.valid & in_ready;
  assign out_fire  = out_valid & dn.ready;

  assign up.ready  = in_ready;
  assign dn.valid  = out_valid;
  assign dn.col    = out_valid ? sel_col : '0;
  assign dn.last   = out_valid & (rd_beat == LAST_BEAT);
  assign busy      = (|full) | (wr_beat != 2'd0);

  always_ff @(posedge clk) begin
    if (in_fire) begin
      bank[wr_sel][wr_beat] <= up.col;
    end
  end

  // A bank being written is never full, and only full banks are read, so both edits hit different bits.
  always_comb begin
    full_nxt = full;
    if (in_fire && (wr_beat == LAST_BEAT)) begin
      full_nxt[wr_sel] = 1'b1;
    end
    if (out_fire && (rd_beat == LAST_BEAT)) begin
      full_nxt[rd_sel] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= 2'b00;
      wr_sel  <= 1'b0;
      rd_sel  <= 1'b0;
      wr_beat <= 2'd0;
      rd_beat <= 2'd0;
    end else begin
      full <= full_nxt;
      if (in_fire) begin
        wr_beat <= wr_beat + 2'd1;
        if (wr_beat == LAST_BEAT) begin
          wr_sel <= ~wr_sel;
        end
      end
      if (out_fire) begin
        rd_beat <= rd_beat + 2'd1;
        if (rd_beat == LAST_BEAT) begin
          rd_sel <= ~rd_sel;
        end
      end
    end
  end

  assign rd_state = {bank[rd_sel][0], bank[rd_sel][1], bank[rd_sel][2], bank[rd_sel][3]};

  aes_shift_rows_perm #(
    .INVERSE (INVERSE)
  ) u_perm (
    .din  (rd_state),
    .dout (perm_state)
  );

  always_comb begin
    sel_col = '0;
    case (rd_beat)
      2'd0:    sel_col = perm_state[127:96];
      2'd1:    sel_col = perm_state[95:64];
      2'd2:    sel_col = perm_state[63:32];
      default: sel_col = perm_state[31:0];
    endcase
  end

endmodule

// File: tb/tb_aes_inv_shift_rows_stream.sv
// tb/tb_aes_inv_shift_rows_stream.sv - scoreboard bench for the InvShiftRows stream stage
module tb_aes_inv_shift_rows_stream;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, lb_busy_f, lb_busy_i;

  always #5 clk = ~clk;

  aes_inv_shift_rows_stream_if a_up ();
  aes_inv_shift_rows_stream_if a_dn ();
  aes_inv_shift_rows_stream_if lb_up ();
  aes_inv_shift_rows_stream_if lb_mid ();
  aes_inv_shift_rows_stream_if lb_dn ();

  aes_inv_shift_rows_stream #(.INVERSE(1'b1)) dut (
    .clk (clk), .rst (rst), .up (a_up), .dn (a_dn), .busy (busy)
  );

  aes_inv_shift_rows_stream #(.INVERSE(1'b0)) lb_fwd (
    .clk (clk), .rst (rst), .up (lb_up), .dn (lb_mid), .busy (lb_busy_f)
  );

  aes_inv_shift_rows_stream #(.INVERSE(1'b1)) lb_inv (
    .clk (clk), .rst (rst), .up (lb_mid), .dn (lb_dn), .busy (lb_busy_i)
  );

  int total = 0;
  int bad   = 0;

  // Hand-computed InvShiftRows vectors: FIPS-197 C.1, identity-row pattern, counting pattern.
  word_t vin  [0:2][0:3] = '{
    '{32'h7ad5fda7, 32'h89ef4e27, 32'h2bca100b, 32'h3d9ff59f},
    '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff},
    '{32'h01020304, 32'h05060708, 32'h090a0b0c, 32'h0d0e0f10}};
  word_t vout [0:2][0:3] = '{
    '{32'h7a9f1027, 32'h89d5f50b, 32'h2beffd9f, 32'h3dca4ea7},
    '{32'h00ddaa77, 32'h4411eebb, 32'h885522ff, 32'hcc996633},
    '{32'h010e0b08, 32'h05020f0c, 32'h09060310, 32'h0d0a0704}};

  logic [32:0] exp_q [$];
  logic [32:0] lb_q  [$];

  int  fires     = 0;
  int  gaps      = 0;
  int  stall_cnt = 0;
  bit  gap_mon   = 1'b0;
  bit  seen      = 1'b0;
  int  lb_rx     = 0;
  bit  lb_done   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor for the main DUT.
  always @(negedge clk) begin
    logic [32:0] e;
    if (a_dn.valid && a_dn.ready) begin
      fires++;
      if (gap_mon) seen = 1'b1;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got col %h with nothing pending", a_dn.col);
      end else begin
        e = exp_q.pop_front();
        check("out_col", a_dn.col, e[31:0]);
        check("out_last", 32'(a_dn.last), 32'(e[32]));
      end
    end else if (gap_mon && seen && exp_q.size() != 0 && !a_dn.valid) begin
      gaps++;
    end
  end

  // Scoreboard monitor for the forward->inverse loopback pair.
  always @(negedge clk) begin
    logic [32:0] e;
    if (lb_dn.valid && lb_dn.ready) begin
      lb_rx++;
      if (lb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL lb_unexpected: got col %h with nothing pending", lb_dn.col);
      end else begin
        e = lb_q.pop_front();
        check("lb_col", lb_dn.col, e[31:0]);
        check("lb_last", 32'(lb_dn.last), 32'(e[32]));
      end
    end
  end

  // All stimulus tasks start and end at posedge+1.
  task automatic send_col(input word_t c);
    int n;
    n = 0;
    a_up.valid = 1'b1;
    a_up.col   = c;
    @(negedge clk);
    while (!a_up.ready && n < 2000) begin
      n++;
      @(negedge clk);
    end
    stall_cnt += n;
    if (n >= 2000) check("send_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    a_up.valid = 1'b0;
  endtask

  task automatic push_exp(input int k);
    for (int c = 0; c < 4; c++) exp_q.push_back({(c == 3), vout[k][c]});
  endtask

  task automatic send_state(input int k);
    push_exp(k);
    for (int c = 0; c < 4; c++) send_col(vin[k][c]);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin : lb_ready_gen
    lb_dn.ready = 1'b0;
    wait (lb_done == 1'b0 && rst == 1'b0);
    while (!lb_done) begin
      @(posedge clk);
      #1;
      lb_dn.ready = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin : main
    word_t w;
    int    n;
    a_up.valid  = 1'b0;
    a_up.col    = '0;
    a_up.last   = 1'b0;
    a_dn.ready  = 1'b0;
    lb_up.valid = 1'b0;
    lb_up.col   = '0;
    lb_up.last  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready_during", 32'(a_up.ready), 32'd1);
    check("rst_out_valid_during", 32'(a_dn.valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(a_dn.valid), 32'd0);
    check("rst_out_last", 32'(a_dn.last), 32'd0);
    check("rst_in_ready", 32'(a_up.ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("empty_out_col", a_dn.col, 32'd0);
    @(posedge clk);
    #1;

    // FIPS-197 inverse round vector and first-output latency.
    a_dn.ready = 1'b1;
    push_exp(0);
    for (int c = 0; c < 3; c++) send_col(vin[0][c]);
    check("t1_no_early_valid", 32'(a_dn.valid), 32'd0);
    send_col(vin[0][3]);
    @(negedge clk);
    check("t1_latency_valid", 32'(a_dn.valid), 32'd1);
    @(posedge clk);
    #1;
    drain("t1_drain");

    // Identity-row pattern.
    send_state(1);
    drain("t6_drain");

    // Back-to-back states with no output bubbles.
    fires = 0;
    gaps = 0;
    stall_cnt = 0;
    seen = 1'b0;
    gap_mon = 1'b1;
    for (int k = 0; k < 3; k++) send_state(k);
    drain("t2_drain");
    gap_mon = 1'b0;
    check("t2_fires", 32'(fires), 32'd12);
    check("t2_gaps", 32'(gaps), 32'd0);
    check("t2_in_stalls", 32'(stall_cnt), 32'd0);

    // Backpressure: both banks fill, then release.
    a_dn.ready = 1'b0;
    send_state(0);
    send_state(1);
    @(negedge clk);
    check("t3_in_ready_low", 32'(a_up.ready), 32'd0);
    check("t3_busy", 32'(busy), 32'd1);
    repeat (4) @(negedge clk);
    check("t3_hold_valid", 32'(a_dn.valid), 32'd1);
    check("t3_hold_col", a_dn.col, vout[0][0]);
    check("t3_hold_last", 32'(a_dn.last), 32'd0);
    @(posedge clk);
    #1;
    fork
      send_state(2);
    join_none
    @(posedge clk);
    #1;
    a_dn.ready = 1'b1;
    wait fork;
    drain("t3_drain");

    // Reset with one full bank pending and a half-written second bank.
    a_dn.ready = 1'b0;
    send_state(2);
    send_col(vin[0][0]);
    send_col(vin[0][1]);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t4_out_valid", 32'(a_dn.valid), 32'd0);
    check("t4_in_ready", 32'(a_up.ready), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    a_dn.ready = 1'b1;
    send_state(1);
    drain("t4_drain");
    repeat (4) @(negedge clk);
    check("t4_idle_valid", 32'(a_dn.valid), 32'd0);
    @(posedge clk);
    #1;

    // Loopback forward->inverse with random states and handshakes.
    for (int s = 0; s < 1000; s++) begin
      for (int c = 0; c < 4; c++) begin
        w = $urandom;
        lb_q.push_back({(c == 3), w});
        while ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
        lb_up.valid = 1'b1;
        lb_up.col   = w;
        n = 0;
        @(negedge clk);
        while (!lb_up.ready && n < 2000) begin
          n++;
          @(negedge clk);
        end
        if (n >= 2000) check("lb_send_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        lb_up.valid = 1'b0;
      end
    end
    n = 0;
    while (lb_rx < 4000 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    lb_done = 1'b1;
    check("lb_rx_count", 32'(lb_rx), 32'd4000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
